// File: rtl/soc_system_status_temp_bed_if.sv
// Avalon-MM slave bus bundle for the bed-temperature status port.
// The master drives the strobes and write data; the slave returns read data.
interface soc_system_status_temp_bed_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read_n,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read_n,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_status_temp_bed.sv
// Bed-temperature input port: latches ADC samples, compares them against the max-temperature limit,
// and exposes sample/status/mask/event registers with a level interrupt to the HPS.
module soc_system_status_temp_bed #(
  parameter int unsigned           DATA_WIDTH   = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_SAMPLE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  soc_system_status_temp_bed_if.slave   bus,
  input  logic [DATA_WIDTH-1:0]         in_port,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         limit,
  output logic                          irq
);

  localparam logic [1:0] AddrSample = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrMask   = 2'd2;
  localparam logic [1:0] AddrEvent  = 2'd3;

  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  new_q, new_d;
  logic                  overrun_q, overrun_d;
  logic                  over_q, over_d;
  logic [2:0]            mask_q, mask_d;
  logic [2:0]            event_q, event_d;
  logic                  irq_q, irq_d;

  logic       rd, wr;
  logic       overrun_set, over_rise;
  logic [2:0] event_set, event_clr;
  logic       unused_wdata;

  assign rd           = bus.chipselect & ~bus.read_n;
  assign wr           = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:3];

  always_comb begin
    sample_d    = in_valid ? in_port : sample_q;
    // Set wins over the read-side clear.
    new_d       = in_valid | (new_q & ~(rd && (bus.address == AddrSample)));
    overrun_set = in_valid & new_q;
    overrun_d   = overrun_set |
                  (overrun_q & ~(wr && (bus.address == AddrStatus) && bus.writedata[1]));
    // Compare uses the registered sample, so OVER trails a new sample by one cycle.
    over_d      = sample_q > limit;
    over_rise   = over_d & ~over_q;
    mask_d      = (wr && (bus.address == AddrMask)) ? bus.writedata[2:0] : mask_q;
    event_set   = {over_rise, overrun_set, in_valid};
    event_clr   = (wr && (bus.address == AddrEvent)) ? bus.writedata[2:0] : 3'b000;
    event_d     = event_set | (event_q & ~event_clr);
    irq_d       = |(event_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q  <= RESET_SAMPLE;
      new_q     <= 1'b0;
      overrun_q <= 1'b0;
      over_q    <= 1'b0;
      mask_q    <= 3'b000;
      event_q   <= 3'b000;
      irq_q     <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      new_q     <= new_d;
      overrun_q <= overrun_d;
      over_q    <= over_d;
      mask_q    <= mask_d;
      event_q   <= event_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    bus.readdata = 32'h0;
    unique case (bus.address)
      AddrSample: bus.readdata = {{(32 - DATA_WIDTH){1'b0}}, sample_q};
      AddrStatus: bus.readdata = {29'h0, over_q, overrun_q, new_q};
      AddrMask:   bus.readdata = {29'h0, mask_q};
      AddrEvent:  bus.readdata = {29'h0, event_q};
      default:    bus.readdata = 32'h0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_soc_system_status_temp_bed.sv
// Bench for the bed-temperature status port: directed vector table, hand-written
// same-cycle/reset sequences, then random traffic against a behavioural model.
module tb_soc_system_status_temp_bed;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_port = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] limit = 12'hFFF;
  logic          irq;

  soc_system_status_temp_bed_if bus ();

  soc_system_status_temp_bed #(
    .DATA_WIDTH  (DW),
    .RESET_SAMPLE(12'h000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .in_valid(in_valid),
    .limit   (limit),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [DW-1:0] m_sample;
  logic          m_new, m_overrun, m_over, m_irq;
  logic [2:0]    m_mask, m_event;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {20'h0, m_sample};
      2'd1:    return {29'h0, m_over, m_overrun, m_new};
      2'd2:    return {29'h0, m_mask};
      default: return {29'h0, m_event};
    endcase
  endfunction

  // One clock: model the register rules from the current inputs, advance, then idle the bus.
  task automatic tick();
    logic          rd_s, wr_s, ovr, over_n, irq_n;
    logic [DW-1:0] sample_n;
    logic          new_n, overrun_n;
    logic [2:0]    mask_n, event_n;
    rd_s = bus.chipselect && !bus.read_n;
    wr_s = bus.chipselect && !bus.write_n;
    if (reset) begin
      sample_n = '0; new_n = 0; overrun_n = 0; over_n = 0;
      mask_n = 0; event_n = 0; irq_n = 0;
    end else begin
      sample_n = in_valid ? in_port : m_sample;
      if (in_valid) new_n = 1;
      else if (rd_s && bus.address == 2'd0) new_n = 0;
      else new_n = m_new;
      ovr = in_valid && m_new;
      if (ovr) overrun_n = 1;
      else if (wr_s && bus.address == 2'd1 && bus.writedata[1]) overrun_n = 0;
      else overrun_n = m_overrun;
      over_n = (int'(m_sample) > int'(limit));
      mask_n = (wr_s && bus.address == 2'd2) ? bus.writedata[2:0] : m_mask;
      for (int k = 0; k < 3; k++) begin
        logic setk;
        setk = (k == 0) ? in_valid : (k == 1) ? ovr : (over_n && !m_over);
        if (setk) event_n[k] = 1;
        else if (wr_s && bus.address == 2'd3 && bus.writedata[k]) event_n[k] = 0;
        else event_n[k] = m_event[k];
      end
      irq_n = (m_event & m_mask) != 3'b000;
    end
    @(posedge clk);
    #1;
    m_sample = sample_n; m_new = new_n; m_overrun = overrun_n; m_over = over_n;
    m_mask = mask_n; m_event = event_n; m_irq = irq_n;
    bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1; in_valid = 0;
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.address = a;
    #1;
    check(name, bus.readdata, exp);
  endtask

  typedef enum logic [2:0] {VIdle, VRd, VWr, VSmp, VLim, VPeek, VIrq, VRst} vop_e;
  typedef struct {
    vop_e        op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input vop_e op, input logic [1:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    bus.address = 0; bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1; bus.writedata = 0;
    m_sample = 0; m_new = 0; m_overrun = 0; m_over = 0; m_mask = 0; m_event = 0; m_irq = 0;

    // Reset state and first sample (limit 0xFFF)
    add(VRst, 0, 0, 0);
    add(VPeek, 0, 0, 0); add(VPeek, 1, 0, 0); add(VPeek, 2, 0, 0); add(VPeek, 3, 0, 0);
    add(VIrq, 0, 0, 0);
    add(VSmp, 0, 32'h0A5, 0);
    add(VPeek, 0, 0, 32'h0A5); add(VPeek, 1, 0, 32'h1); add(VPeek, 3, 0, 32'h1);
    // Interrupt path
    add(VRd, 0, 0, 0); add(VWr, 3, 32'h7, 0); add(VWr, 2, 32'h1, 0);
    add(VSmp, 0, 32'h0B0, 0); add(VIrq, 0, 0, 0);
    add(VIdle, 0, 0, 0); add(VIrq, 0, 0, 1);
    add(VPeek, 1, 0, 32'h1); add(VRd, 0, 0, 0); add(VPeek, 1, 0, 32'h0);
    add(VWr, 3, 32'h1, 0); add(VIrq, 0, 0, 1); add(VPeek, 3, 0, 0);
    add(VIdle, 0, 0, 0); add(VIrq, 0, 0, 0);
    // Overrun
    add(VSmp, 0, 32'h100, 0); add(VSmp, 0, 32'h200, 0);
    add(VPeek, 0, 0, 32'h200); add(VPeek, 1, 0, 32'h3); add(VPeek, 3, 0, 32'h3);
    add(VWr, 1, 32'h2, 0); add(VPeek, 1, 0, 32'h1); add(VPeek, 3, 0, 32'h3);
    // Over-limit compare
    add(VWr, 3, 32'h7, 0); add(VRd, 0, 0, 0); add(VLim, 0, 32'h300, 0);
    add(VIdle, 0, 0, 0); add(VSmp, 0, 32'h300, 0); add(VIdle, 0, 0, 0); add(VIdle, 0, 0, 0);
    add(VPeek, 1, 0, 32'h1); add(VPeek, 3, 0, 32'h1);
    add(VRd, 0, 0, 0); add(VSmp, 0, 32'h301, 0); add(VPeek, 1, 0, 32'h1);
    add(VIdle, 0, 0, 0); add(VPeek, 1, 0, 32'h5); add(VPeek, 3, 0, 32'h5);
    add(VWr, 3, 32'h7, 0); add(VPeek, 3, 0, 0); add(VLim, 0, 32'h100, 0);
    add(VIdle, 0, 0, 0); add(VIdle, 0, 0, 0);
    add(VPeek, 3, 0, 0); add(VPeek, 1, 0, 32'h5);

    tick();
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d_a%0d", i, vecs[i].addr);
      case (vecs[i].op)
        VIdle: tick();
        VRd: begin
          bus.chipselect = 1; bus.read_n = 0; bus.address = vecs[i].addr; tick();
        end
        VWr: begin
          bus.chipselect = 1; bus.write_n = 0; bus.address = vecs[i].addr;
          bus.writedata = vecs[i].data; tick();
        end
        VSmp: begin
          in_valid = 1; in_port = vecs[i].data[DW-1:0]; tick();
        end
        VLim:  limit = vecs[i].data[DW-1:0];
        VPeek: peek(vecs[i].addr, vecs[i].exp, nm);
        VIrq:  check({nm, "_irq"}, {31'h0, irq}, vecs[i].exp);
        default: begin
          reset = 1; tick(); reset = 0;
        end
      endcase
    end

    // Read of SAMPLE in the same cycle as a strobe: NEW stays set (and it overruns)
    bus.chipselect = 1; bus.read_n = 0; bus.address = 0; in_valid = 1; in_port = 12'h050;
    tick();
    peek(1, 32'h7, "rd_and_valid_status");
    bus.chipselect = 1; bus.write_n = 0; bus.address = 3; bus.writedata = 32'h7;
    tick();
    peek(3, 32'h0, "event_cleared");
    // W1C of EVENT[0] in the same cycle as a sample: set wins
    bus.chipselect = 1; bus.write_n = 0; bus.address = 3; bus.writedata = 32'h1;
    in_valid = 1; in_port = 12'h060;
    tick();
    peek(3, 32'h3, "w1c_and_valid_event");
    peek(0, 32'h060, "w1c_and_valid_sample");

    // Reset mid-stream with irq asserted; strobe during reset is discarded
    bus.chipselect = 1; bus.write_n = 0; bus.address = 2; bus.writedata = 32'h7;
    tick();
    tick();
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    reset = 1; in_valid = 1; in_port = 12'h777;
    tick();
    reset = 0;
    check("post_reset_irq", {31'h0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) peek(2'(a), 32'h0, $sformatf("post_reset_a%0d", a));
    tick();
    peek(0, 32'h0, "post_reset_idle_sample");
    check("post_reset_idle_irq", {31'h0, irq}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      reset = ($urandom_range(0, 79) == 0);
      bus.address = 2'($urandom_range(0, 3));
      bus.chipselect = (r < 60);
      bus.read_n = !(r < 30 || r == 55);
      bus.write_n = !(r >= 30 && r < 60);
      bus.writedata = $urandom;
      in_valid = ($urandom_range(0, 2) == 0);
      in_port = DW'($urandom);
      if ($urandom_range(0, 15) == 0) limit = DW'($urandom);
      tick();
      check($sformatf("rnd%0d_irq", n), {31'h0, irq}, {31'h0, m_irq});
      begin
        logic [1:0] pa;
        pa = 2'($urandom_range(0, 3));
        peek(pa, exp_rd(pa), $sformatf("rnd%0d_a%0d", n, pa));
      end
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_system_status_temp_bed.md
Name: soc_system_status_temp_bed

Overview:
Avalon-MM slave input port that carries the bed temperature from the fabric to the HPS. It is the read-back counterpart of the max-bed-temperature setting register. It latches 12-bit samples from the bed thermistor ADC block on a valid strobe and compares each sample against the programmed limit. It exposes sample, status, interrupt-mask and write-1-to-clear event registers, and drives a level interrupt to the HPS.

Parameters:
DATA_WIDTH, 12, width of in_port, limit and the SAMPLE field (1..31)
RESET_SAMPLE, 0, SAMPLE register value after reset

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
read_n  in  1  active-low read strobe; qualified by chipselect
write_n  in  1  active-low write strobe; qualified by chipselect
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data; combinational from address; unused bits 0
in_port  in  DATA_WIDTH  ADC sample, synchronous to clk
in_valid  in  1  one-cycle sample strobe, synchronous to clk
limit  in  DATA_WIDTH  max bed temperature from the settings register
irq  out  1  registered level interrupt to the HPS

Behaviour:
- Strobes: rd = chipselect & ~read_n; wr = chipselect & ~write_n.
- Register map:
  - Address 0, SAMPLE (RO): bits [DATA_WIDTH-1:0] hold the last latched sample.
  - Address 1, STATUS: bit0 NEW (RO), bit1 OVERRUN (W1C), bit2 OVER (RO).
  - Address 2, MASK (RW): bits [2:0].
  - Address 3, EVENT (W1C): bits [2:0]; bit0 sample, bit1 overrun, bit2 over-limit rise.
- Writes to RO fields and unused bits are ignored. Reads of unused bits return 0.
- Reset values: SAMPLE=RESET_SAMPLE; NEW, OVERRUN, OVER, MASK and EVENT = 0; irq=0. readdata follows the map, so it reads 0 except SAMPLE at address 0.
- Sample latch:
  - When in_valid=1 at edge N, SAMPLE<=in_port, NEW<=1 and EVENT[0]<=1.
  - The new value is visible on readdata from cycle N+1.
  - in_valid is honoured every cycle, including back-to-back strobes.
- NEW clear: rd at address 0 clears NEW at that edge. If in_valid occurs in the same cycle, set wins and NEW stays 1.
- Overrun:
  - in_valid while NEW=1 (before the clearing edge) sets OVERRUN and EVENT[1]. SAMPLE is still overwritten with the newest value.
  - Writing bit1=1 to STATUS clears OVERRUN. If a new overrun occurs in the same cycle, set wins.
- Over-limit compare:
  - OVER<=(SAMPLE > limit), unsigned strict compare, registered every cycle.
  - OVER therefore updates one cycle after SAMPLE or limit changes: in_valid at N gives OVER at N+2.
  - A 0->1 transition of OVER sets EVENT[2] in the same edge OVER rises. Falling edges set nothing.
  - sample == limit gives OVER=0.
- EVENT clear: writing 1 to bit k clears EVENT[k]; writing 0 leaves it unchanged. A set condition in the same cycle as its clear wins.
- irq <= |(EVENT & MASK), registered, so it asserts one cycle after the enabling EVENT or MASK change. Masking an active event deasserts irq one cycle later.
- Reset mid-operation: every register returns to its reset value at the next edge. in_valid during reset is discarded.
- rd and wr are never asserted together (Avalon). If both are asserted anyway, the write takes effect and the read side-effect still applies.

Test Plan:
1. Reset, then read addresses 0-3 -> all 0, irq=0. Pulse in_valid with in_port=0x0A5 -> SAMPLE reads 0x0A5 next cycle; STATUS=0x1 (limit=0xFFF); EVENT=0x1.
2. MASK=0x1, pulse in_valid -> irq=1 two edges after the strobe. Read address 0 -> NEW=0. Write EVENT=0x1 -> irq=0 one cycle after EVENT clears.
3. Two in_valid pulses 0x100 then 0x200 with no read in between -> SAMPLE=0x200, STATUS=0x3, EVENT=0x3. Write STATUS=0x2 -> OVERRUN=0, NEW still 1.
4. limit=0x300: sample 0x300 -> OVER=0; sample 0x301 -> OVER=1 at N+2 and EVENT[2]=1. Lower limit with OVER already 1 -> no new EVENT[2].
5. Same-cycle events: in_valid together with a read of address 0 -> NEW stays 1. Sample event together with a W1C of EVENT[0] -> EVENT[0] stays 1.
6. Assert reset for 1 cycle mid-stream with MASK=0x7 and irq=1 -> all registers return to reset values and irq=0 on the next cycle.
